// File: rtl/ifetch.sv
// ---------------------------------------------------------------------------
// ifetch -- single-outstanding instruction fetch unit.
//
// Accepts a word-aligned PC from upstream, issues one memory read for it,
// and hands the returned instruction (with its PC) to decode. Misaligned
// PCs and bus errors are reported as one-cycle pulses. A flush abandons
// the current fetch. If a request has already been granted, the response
// is still owed, so the DRAIN state swallows it.
//
// Optional feature (compile-time macro IFETCH_TIMEOUT_EN):
//   When defined, a WAIT-cycle counter raises fetch_err_o after TIMEOUT
//   WAIT cycles without a response, then drains the late response.
//   When undefined, WAIT lasts until the response arrives.
//
// Parameters:
//   DATA_WIDTH  PC / address width
//   INST_WIDTH  instruction width
//   TIMEOUT     WAIT-cycle limit (only with IFETCH_TIMEOUT_EN)
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-low reset
//   pc_valid_i/pc_i   upstream PC, accepted when pc_ready_o is high
//   pc_ready_o        high only in IDLE, out of reset, with no flush
//   mem_req_o/addr_o  read request, held until mem_gnt_i
//   mem_gnt_i         request accepted
//   mem_rvalid_i      response valid, carrying mem_rdata_i / mem_err_i
//   inst_valid_o      instruction to decode, held until inst_ready_i
//   inst_o/inst_pc_o  instruction and its PC
//   flush_i           discard the current fetch
//   fetch_err_o       one-cycle bus-error (or timeout) pulse
//   misalign_o        one-cycle misaligned-PC pulse
// ---------------------------------------------------------------------------
module ifetch #(
  parameter int DATA_WIDTH = 64,
  parameter int INST_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pc_valid_i,
  input  logic [DATA_WIDTH-1:0] pc_i,
  output logic                  pc_ready_o,
  output logic                  mem_req_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [INST_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_err_i,
  output logic                  inst_valid_o,
  output logic [INST_WIDTH-1:0] inst_o,
  output logic [DATA_WIDTH-1:0] inst_pc_o,
  input  logic                  inst_ready_i,
  input  logic                  flush_i,
  output logic                  fetch_err_o,
  output logic                  misalign_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t                  state_reg, state_next;
  logic [DATA_WIDTH-1:0]   pc_reg, pc_next;
  logic [INST_WIDTH-1:0]   inst_reg, inst_next;
  logic                    fetch_err_reg, fetch_err_next;
  logic                    misalign_reg, misalign_next;
  logic                    timeout_hit;

`ifdef IFETCH_TIMEOUT_EN
  // Counts completed WAIT cycles. It sits at zero outside WAIT, which
  // clears it on every WAIT entry without a dedicated entry condition.
  logic [7:0] wait_cnt_reg, wait_cnt_next;

  always_comb begin
    wait_cnt_next = '0;
    if (state_reg == WAIT) begin
      wait_cnt_next = wait_cnt_reg + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_cnt_reg <= '0;
    end else begin
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  // Fires in the TIMEOUT-th WAIT cycle, so the error pulse follows it.
  assign timeout_hit = (state_reg == WAIT) && (wait_cnt_reg == 8'(TIMEOUT - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT == 0);
  assign timeout_hit        = 1'b0;
`endif

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= IDLE;
      pc_reg        <= '0;
      inst_reg      <= '0;
      fetch_err_reg <= 1'b0;
      misalign_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      inst_reg      <= inst_next;
      fetch_err_reg <= fetch_err_next;
      misalign_reg  <= misalign_next;
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    inst_next      = inst_reg;
    fetch_err_next = 1'b0;
    misalign_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (pc_valid_i && !flush_i) begin
          if (pc_i[1:0] == 2'b00) begin
            pc_next    = pc_i;
            state_next = REQ;
          end else begin
            misalign_next = 1'b1;
          end
        end
      end

      REQ: begin
        if (flush_i) begin
          // A grant in the flush cycle still owes a response: drain it.
          state_next = mem_gnt_i ? DRAIN : IDLE;
        end else if (mem_gnt_i) begin
          state_next = WAIT;
        end
      end

      WAIT: begin
        if (flush_i) begin
          state_next = mem_rvalid_i ? IDLE : DRAIN;
        end else if (mem_rvalid_i) begin
          if (mem_err_i) begin
            fetch_err_next = 1'b1;
            state_next     = IDLE;
          end else begin
            inst_next  = mem_rdata_i;
            state_next = HOLD;
          end
        end else if (timeout_hit) begin
          fetch_err_next = 1'b1;
          state_next     = DRAIN;
        end
      end

      HOLD: begin
        if (flush_i || inst_ready_i) begin
          state_next = IDLE;
        end
      end

      DRAIN: begin
        if (mem_rvalid_i) begin
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // rst is folded in so upstream never sees ready while held in reset.
  assign pc_ready_o   = rst && (state_reg == IDLE) && !flush_i;
  assign mem_req_o    = (state_reg == REQ);
  assign mem_addr_o   = pc_reg;
  assign inst_valid_o = (state_reg == HOLD);
  assign inst_o       = inst_reg;
  assign inst_pc_o    = pc_reg;
  assign fetch_err_o  = fetch_err_reg;
  assign misalign_o   = misalign_reg;

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, PC/address width.
REQ-002 SHALL have parameter INST_WIDTH, default 32, instruction width.
REQ-003 SHALL have parameter TIMEOUT, default 255, WAIT-cycle limit (used only with IFETCH_TIMEOUT_EN).
REQ-004 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port pc_valid_i  input  1  upstream PC valid.
REQ-007 SHALL have port pc_i  input  DATA_WIDTH  fetch address.
REQ-008 SHALL have port pc_ready_o  output  1  ifetch accepts PC.
REQ-009 SHALL have port mem_req_o  output  1  memory read request.
REQ-010 SHALL have port mem_addr_o  output  DATA_WIDTH  request address.
REQ-011 SHALL have port mem_gnt_i  input  1  memory accepted request.
REQ-012 SHALL have port mem_rvalid_i  input  1  read data valid.
REQ-013 SHALL have port mem_rdata_i  input  INST_WIDTH  read data.
REQ-014 SHALL have port mem_err_i  input  1  bus error, qualified by mem_rvalid_i.
REQ-015 SHALL have port inst_valid_o  output  1  instruction to decode valid.
REQ-016 SHALL have port inst_o  output  INST_WIDTH  instruction.
REQ-017 SHALL have port inst_pc_o  output  DATA_WIDTH  PC of inst_o.
REQ-018 SHALL have port inst_ready_i  input  1  decode accepts.
REQ-019 SHALL have port flush_i  input  1  discard current fetch.
REQ-020 SHALL have port fetch_err_o  output  1  one-cycle FetchError exception pulse.
REQ-021 SHALL have port misalign_o  output  1  one-cycle misaligned-PC pulse.

Function
REQ-022 SHALL implement FSM states IDLE, REQ, WAIT, HOLD, DRAIN.
REQ-023 IDLE: pc_ready_o=1; pc_valid_i with pc_i[1:0]==0 SHALL latch PC, go REQ next cycle.
REQ-024 IDLE: pc_valid_i with pc_i[1:0]!=0 SHALL pulse misalign_o next cycle, stay IDLE, issue no request.
REQ-025 REQ: mem_req_o=1, mem_addr_o=latched PC, held stable until mem_gnt_i; gnt -> WAIT.
REQ-026 WAIT: mem_rvalid_i && !mem_err_i SHALL capture mem_rdata_i into inst_o, go HOLD.
REQ-027 WAIT: mem_rvalid_i && mem_err_i SHALL pulse fetch_err_o one cycle, go IDLE, no inst_valid_o.
REQ-028 HOLD: inst_valid_o=1; inst_o/inst_pc_o stable until inst_ready_i; handshake -> IDLE.
REQ-029 At most one memory request outstanding; pc_ready_o=0 outside IDLE.
REQ-030 Minimum latency pc accept -> inst_valid_o = 3 cycles (gnt and rvalid each in first possible cycle).
REQ-031 flush_i in REQ before gnt, or HOLD: SHALL go IDLE next cycle, drop data, no pulses.
REQ-032 flush_i in REQ same cycle as gnt, or in WAIT without rvalid: SHALL go DRAIN; DRAIN discards next rvalid (incl. error) then IDLE.
REQ-033 flush_i in WAIT same cycle as rvalid: response discarded, go IDLE, no fetch_err_o.
REQ-034 flush_i in IDLE SHALL block PC acceptance that cycle (pc_ready_o=0).
REQ-035 PC arithmetic none; addresses passed unmodified, full DATA_WIDTH.

Reset
REQ-036 rst==0 at clk edge SHALL force IDLE from any state, abandoning any in-flight request; late rvalid after reset ignored in IDLE.
REQ-037 Reset values: pc_ready_o=1 after release, mem_req_o=0, mem_addr_o=0, inst_valid_o=0, inst_o=0, inst_pc_o=0, fetch_err_o=0, misalign_o=0; pc_ready_o=0 while rst==0.

Configuration
REQ-038 Macro IFETCH_TIMEOUT_EN defined: 8-bit counter cleared on WAIT entry, increments each WAIT cycle; reaching TIMEOUT without rvalid SHALL pulse fetch_err_o and go DRAIN.
REQ-039 Macro IFETCH_TIMEOUT_EN undefined: no counter, WAIT indefinitely.

Verification
REQ-040 Reset, pc_i=0x80000000 valid, gnt and rvalid immediate, rdata=0x00000013 -> inst_valid_o cycle 3, inst_o=0x00000013, inst_pc_o=0x80000000.
REQ-041 pc_i=0x80000002 -> misalign_o one pulse, mem_req_o never asserted.
REQ-042 gnt delayed 4 cycles, inst_ready_i low 5 cycles in HOLD -> mem_addr_o stable throughout, inst_o stable, single handshake.
REQ-043 rvalid with mem_err_i=1 -> fetch_err_o one pulse, inst_valid_o stays 0, back to IDLE.
REQ-044 flush_i in WAIT, rvalid 2 cycles later -> response dropped, inst_valid_o 0, next PC fetch correct.
REQ-045 IFETCH_TIMEOUT_EN, TIMEOUT=8, no rvalid -> fetch_err_o after 8 WAIT cycles; rst low mid-WAIT -> all outputs reset values next cycle.
